// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and types for the segmented pipelined adder/subtractor.
// Operation encoding, default geometry and the pipeline-depth helper.
package pipelined_addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEFAULT_WIDTH = 48;
    localparam int DEFAULT_SEG   = 12;

    // Guarded so an illegal SEG still elaborates far enough to report the error.
    function automatic int nseg(input int width, input int seg);
        return (seg > 0) ? width / seg : 1;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle of the pipelined adder/subtractor.
// No backpressure: the master presents ops, the slave returns registered results.
interface pipelined_addsub_if
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             op;
    logic             cin;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, op, cin, x, y,
        input  out_valid, s, c_out, ovf
    );

    modport slave (
        input  in_valid, op, cin, x, y,
        output out_valid, s, c_out, ovf
    );

endinterface

// File: rtl/pipelined_addsub_adder_segment.sv
// Combinational SEG-bit ripple adder slice; zero latency, no flow control.
// Exposes the carry into its MSB so the top slice can form signed overflow.
module adder_segment
    import pipelined_addsub_pkg::*;
#(
    parameter int SEG = DEFAULT_SEG
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] s_o,
    output logic           c_o,
    output logic           c_msb_o
);

    logic carry;

    always_comb begin
        s_o     = '0;
        c_msb_o = 1'b0;
        carry   = c_i;
        for (int i = 0; i < SEG; i++) begin
            if (i == SEG - 1) begin
                c_msb_o = carry;
            end
            s_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry  = (a_i[i] & b_i[i]) | (a_i[i] & carry) | (b_i[i] & carry);
        end
        c_o = carry;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub with one register stage per SEG-bit carry segment; latency NSEG+1 enabled cycles.
// No backpressure: one op per enabled cycle, ce=0 freezes the whole pipe in place.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG   = DEFAULT_SEG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    pipelined_addsub_if.slave  bus
);

    localparam int NSEG = nseg(WIDTH, SEG);

    if (SEG < 1 || SEG > WIDTH || (WIDTH % ((SEG > 0) ? SEG : 1)) != 0) begin : g_bad_param
        $error("pipelined_addsub: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
    end

    // Stage k holds the operands still to be summed (upper slices) and the
    // result slices already produced (lower slices), plus the carry between them.
    logic [WIDTH-1:0] xa_q [0:NSEG-1];
    logic [WIDTH-1:0] ya_q [0:NSEG-1];
    logic [WIDTH-1:0] sa_q [1:NSEG];
    logic [WIDTH-1:0] sa_d [1:NSEG];
    logic [NSEG:0]    cy_q;
    logic [NSEG:0]    vl_q;
    logic             ovf_q;

    logic [SEG-1:0]   seg_s  [0:NSEG-1];
    logic [NSEG-1:0]  seg_co;
    logic [NSEG-1:0]  seg_cm;

    logic             is_sub;

    assign is_sub = (bus.op == OP_SUB);

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .a_i     (xa_q[k][k*SEG +: SEG]),
            .b_i     (ya_q[k][k*SEG +: SEG]),
            .c_i     (cy_q[k]),
            .s_o     (seg_s[k]),
            .c_o     (seg_co[k]),
            .c_msb_o (seg_cm[k])
        );
    end

    always_comb begin
        for (int i = 1; i <= NSEG; i++) begin
            sa_d[i] = (i > 1) ? sa_q[(i > 1) ? i - 1 : 1] : '0;
            sa_d[i][(i-1)*SEG +: SEG] = seg_s[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSEG; i++) begin
                xa_q[i] <= '0;
                ya_q[i] <= '0;
            end
            for (int i = 1; i <= NSEG; i++) begin
                sa_q[i] <= '0;
            end
            cy_q  <= '0;
            vl_q  <= '0;
            ovf_q <= 1'b0;
        end else if (ce) begin
            // Subtract folds into add: invert y and the borrow at capture time.
            xa_q[0] <= bus.x;
            ya_q[0] <= bus.y ^ {WIDTH{is_sub}};
            cy_q[0] <= bus.cin ^ is_sub;
            vl_q[0] <= bus.in_valid;
            for (int i = 1; i < NSEG; i++) begin
                xa_q[i] <= xa_q[i-1];
                ya_q[i] <= ya_q[i-1];
            end
            for (int i = 1; i <= NSEG; i++) begin
                sa_q[i]  <= sa_d[i];
                cy_q[i]  <= seg_co[i-1];
                vl_q[i]  <= vl_q[i-1];
            end
            ovf_q <= seg_co[NSEG-1] ^ seg_cm[NSEG-1];
        end
    end

    assign bus.out_valid = vl_q[NSEG];
    assign bus.s         = sa_q[NSEG];
    assign bus.c_out     = cy_q[NSEG];
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three geometries (8/4, 48/12, 8/8) behind one shared stimulus bus.
// Directed vectors with exact latency, random streams with ce stalls against an arithmetic model.
module tb_pipelined_addsub;
    import pipelined_addsub_pkg::*;

    typedef struct {
        bit       op;
        bit       cin;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] s;
        bit       c;
        bit       ovf;
    } vec_t;

    typedef struct {
        bit          vld;
        logic [63:0] s;
        bit          c;
        bit          ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic        d_ce = 1'b0;
    logic        d_vld = 1'b0;
    logic        d_op = 1'b0;
    logic        d_cin = 1'b0;
    logic [63:0] d_x = '0;
    logic [63:0] d_y = '0;

    logic        o_vld;
    logic [63:0] o_s;
    logic        o_c;
    logic        o_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    vec_t tbl [12];

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(8))  ifa ();
    pipelined_addsub_if #(.WIDTH(48)) ifb ();
    pipelined_addsub_if #(.WIDTH(8))  ifc ();

    assign ifa.in_valid = d_vld;
    assign ifa.op       = d_op;
    assign ifa.cin      = d_cin;
    assign ifa.x        = d_x[7:0];
    assign ifa.y        = d_y[7:0];
    assign ifb.in_valid = d_vld;
    assign ifb.op       = d_op;
    assign ifb.cin      = d_cin;
    assign ifb.x        = d_x[47:0];
    assign ifb.y        = d_y[47:0];
    assign ifc.in_valid = d_vld;
    assign ifc.op       = d_op;
    assign ifc.cin      = d_cin;
    assign ifc.x        = d_x[7:0];
    assign ifc.y        = d_y[7:0];

    logic ce_a, ce_b, ce_c;
    assign ce_a = d_ce && (sel == 2'd0);
    assign ce_b = d_ce && (sel == 2'd1);
    assign ce_c = d_ce && (sel == 2'd2);

    pipelined_addsub #(.WIDTH(8),  .SEG(4))  dut_a (.clk(clk), .rst(rst), .ce(ce_a), .bus(ifa));
    pipelined_addsub #(.WIDTH(48), .SEG(12)) dut_b (.clk(clk), .rst(rst), .ce(ce_b), .bus(ifb));
    pipelined_addsub #(.WIDTH(8),  .SEG(8))  dut_c (.clk(clk), .rst(rst), .ce(ce_c), .bus(ifc));

    always_comb begin
        o_vld = 1'b0;
        o_s   = '0;
        o_c   = 1'b0;
        o_ovf = 1'b0;
        case (sel)
            2'd0: begin o_vld = ifa.out_valid; o_s = 64'(ifa.s); o_c = ifa.c_out; o_ovf = ifa.ovf; end
            2'd1: begin o_vld = ifb.out_valid; o_s = 64'(ifb.s); o_c = ifb.c_out; o_ovf = ifb.ovf; end
            default: begin o_vld = ifc.out_valid; o_s = 64'(ifc.s); o_c = ifc.c_out; o_ovf = ifc.ovf; end
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        d_vld = 1'b0;
        d_op  = 1'b0;
        d_cin = 1'b0;
        d_x   = '0;
        d_y   = '0;
    endtask

    // Exact signed/unsigned arithmetic: x+y+cin or x-y-cin, then wrapped to w bits.
    function automatic exp_t model(input int w, input logic vld, input logic op, input logic cin,
                                   input logic [63:0] x, input logic [63:0] y);
        exp_t   r;
        longint m, ux, uy, sx, sy, u, sv;
        m  = longint'(1) << w;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[w-1] ? ux - m : ux;
        sy = y[w-1] ? uy - m : uy;
        if (op == OP_SUB) begin
            u   = ux - uy - longint'(cin);
            sv  = sx - sy - longint'(cin);
            r.c = (u >= 0);
        end else begin
            u   = ux + uy + longint'(cin);
            sv  = sx + sy + longint'(cin);
            r.c = (u >= m);
        end
        r.s   = 64'(u & (m - 1));
        r.ovf = (sv < -(m / 2)) || (sv >= m / 2);
        r.vld = vld;
        return r;
    endfunction

    task automatic apply_vec(input int lat, input int idx, input vec_t v);
        string tag;
        tag   = $sformatf("tbl%0d_lat%0d", idx, lat);
        d_ce  = 1'b1;
        d_vld = 1'b1;
        d_op  = v.op;
        d_cin = v.cin;
        d_x   = 64'(v.x);
        d_y   = 64'(v.y);
        step();
        drive_idle();
        for (int i = 2; i <= lat; i++) begin
            chk({tag, " early_vld"}, 64'(o_vld), 64'd0);
            step();
        end
        chk({tag, " vld"}, 64'(o_vld), 64'd1);
        chk({tag, " s"},   o_s,        64'(v.s));
        chk({tag, " c"},   64'(o_c),   64'(v.c));
        chk({tag, " ovf"}, 64'(o_ovf), 64'(v.ovf));
        step();
        chk({tag, " dup_vld"}, 64'(o_vld), 64'd0);
    endtask

    // Model queue holds the lat most recent enabled-cycle inputs; its head is
    // what the outputs must show, and it does not move while ce is low.
    task automatic run_stream(input int w, input int lat, input int nops, input int ce_pct,
                              input int vld_pct, input int stall_lo, input int stall_hi,
                              input string tag);
        exp_t        q[$];
        exp_t        e;
        exp_t        idle;
        int          issued, seen, cyc, budget;
        logic [63:0] msk;
        bit          ce_now;
        msk    = (64'd1 << w) - 64'd1;
        issued = 0;
        seen   = 0;
        cyc    = 0;
        budget = nops * 20 + 100;
        idle   = '{vld: 1'b0, s: 64'd0, c: 1'b0, ovf: 1'b0};
        d_ce = 1'b1;
        drive_idle();
        repeat (lat) step();
        q.delete();
        repeat (lat) q.push_back(idle);
        while (seen < nops && cyc < budget) begin
            ce_now = (cyc >= stall_lo && cyc <= stall_hi) ? 1'b0 : ($urandom_range(0, 99) < ce_pct);
            d_ce   = ce_now;
            d_vld  = (issued < nops) && ($urandom_range(0, 99) < vld_pct);
            d_op   = 1'($urandom_range(0, 1));
            d_cin  = 1'($urandom_range(0, 1));
            d_x    = {$urandom, $urandom} & msk;
            d_y    = {$urandom, $urandom} & msk;
            if (ce_now) begin
                q.push_back(model(w, d_vld, d_op, d_cin, d_x, d_y));
                void'(q.pop_front());
                if (d_vld) issued++;
            end
            step();
            e = q[0];
            chk({tag, " vld"}, 64'(o_vld), 64'(e.vld));
            if (e.vld) begin
                chk({tag, " s"},   o_s,        e.s);
                chk({tag, " c"},   64'(o_c),   64'(e.c));
                chk({tag, " ovf"}, 64'(o_ovf), 64'(e.ovf));
            end
            if (ce_now && o_vld) seen++;
            cyc++;
        end
        chk({tag, " result_count"}, 64'(seen), 64'(nops));
        d_ce = 1'b1;
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 8'h3C, 8'h0F, 8'h4C, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 8'h80, 8'h80, 8'hFF, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};

        drive_idle();
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            chk($sformatf("reset%0d vld", k), 64'(o_vld), 64'd0);
            chk($sformatf("reset%0d s", k),   o_s,        64'd0);
            chk($sformatf("reset%0d c", k),   64'(o_c),   64'd0);
            chk($sformatf("reset%0d ovf", k), 64'(o_ovf), 64'd0);
        end
        sel = 2'd0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) apply_vec(3, i, tbl[i]);
        run_stream(8, 3, 16, 100, 100, 8, 9, "a_stall");
        run_stream(8, 3, 200, 70, 70, -1, -1, "a_rand");

        // Three ops in flight, asynchronous reset pulse between clock edges.
        d_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_vld = 1'b1;
            d_op  = 1'($urandom_range(0, 1));
            d_cin = 1'($urandom_range(0, 1));
            d_x   = 64'($urandom_range(0, 255));
            d_y   = 64'($urandom_range(0, 255));
            step();
        end
        drive_idle();
        #2 rst = 1'b1;
        #1;
        chk("midrst vld", 64'(o_vld), 64'd0);
        chk("midrst s",   o_s,        64'd0);
        chk("midrst c",   64'(o_c),   64'd0);
        chk("midrst ovf", 64'(o_ovf), 64'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("postrst%0d vld", i), 64'(o_vld), 64'd0);
        end
        apply_vec(3, 100, tbl[0]);

        sel = 2'd1;
        run_stream(48, 5, 20, 100, 100, 6, 7, "b_stall");
        run_stream(48, 5, 3000, 85, 75, -1, -1, "b_rand");

        sel = 2'd2;
        for (int i = 0; i < 12; i++) apply_vec(2, i, tbl[i]);
        run_stream(8, 2, 200, 80, 80, 5, 6, "c_rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
